// File: rtl/id_stage_pkg.sv
// Shared definitions for the RV32I decode stage: opcodes, control word
// layout, ALU operation encodings and datapath widths.
package id_stage_pkg;

  localparam int unsigned XLEN       = 32;  // only 32 is supported
  localparam int unsigned CTRL_WIDTH = 10;
  localparam int unsigned REG_AW     = 5;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

  // Bit indices of the control word (LSB first).
  localparam int unsigned CTRL_REG_WRITE  = 0;
  localparam int unsigned CTRL_MEM_READ   = 1;
  localparam int unsigned CTRL_MEM_WRITE  = 2;
  localparam int unsigned CTRL_MEM_TO_REG = 3;
  localparam int unsigned CTRL_ALU_SRC    = 4;
  localparam int unsigned CTRL_BRANCH     = 5;
  localparam int unsigned CTRL_JAL        = 6;
  localparam int unsigned CTRL_JALR       = 7;

  // Packed MSB-first so the struct matches the bit indices above.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       jalr;
    logic       jal;
    logic       branch;
    logic       alu_src;
    logic       mem_to_reg;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
  } ctrl_t;

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 register file, x0 hardwired to zero.
//  clk, rst_n           clock, async active-low reset (clears x1..x31)
//  rs1_addr_i/rs2_addr_i read addresses; rd_data1_o/rd_data2_o async read data
//  wr_en_i, wr_addr_i, wr_data_i  synchronous write port with same-cycle bypass
module id_stage_regfile
  import id_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  output logic [XLEN-1:0]   rd_data1_o,
  output logic [XLEN-1:0]   rd_data2_o,
  input  logic              wr_en_i,
  input  logic [REG_AW-1:0] wr_addr_i,
  input  logic [XLEN-1:0]   wr_data_i
);

  logic [XLEN-1:0] regs_q [1:31];
  logic [XLEN-1:0] regs_d [1:31];
  logic            wr_active;

  // Writes to x0 are dropped entirely, which also keeps them out of the bypass.
  assign wr_active = wr_en_i && (wr_addr_i != '0);

  always_comb begin
    // NOTE: start from the current state so every path assigns regs_d and no latch is inferred.
    regs_d = regs_q;
    if (wr_active) regs_d[wr_addr_i] = wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is architectural state that must read 0 after reset, so it is reset like any flop (not inferred as RAM).
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd_data1_o = '0;
    if (rs1_addr_i != '0) begin
      rd_data1_o = (wr_active && wr_addr_i == rs1_addr_i) ? wr_data_i : regs_q[rs1_addr_i];
    end
  end

  always_comb begin
    rd_data2_o = '0;
    if (rs2_addr_i != '0) begin
      rd_data2_o = (wr_active && wr_addr_i == rs2_addr_i) ? wr_data_i : regs_q[rs2_addr_i];
    end
  end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction-decode stage.
//  Inputs : instr_i, pc_incr_i from IF/ID; flush_i from EX; idex_mem_read_i,
//           idex_rd_i from IDEX (load-use check); wb_en_i/wb_addr_i/wb_data_i.
//  Outputs: pc_incr_o, rd_data1_o, rd_data2_o, wr_addr_o, imm_se_o, ctrl_q2_o,
//           stall_o (hold PC and IF/ID), illegal_o.
// All outputs are combinational; the only state lives in the register file.
module id_stage
  import id_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [XLEN-1:0]       instr_i,
  input  logic [XLEN-1:0]       pc_incr_i,
  input  logic                  flush_i,
  input  logic                  idex_mem_read_i,
  input  logic [REG_AW-1:0]     idex_rd_i,
  input  logic                  wb_en_i,
  input  logic [REG_AW-1:0]     wb_addr_i,
  input  logic [XLEN-1:0]       wb_data_i,
  output logic [XLEN-1:0]       pc_incr_o,
  output logic [XLEN-1:0]       rd_data1_o,
  output logic [XLEN-1:0]       rd_data2_o,
  output logic [XLEN-1:0]       wr_addr_o,
  output logic [XLEN-1:0]       imm_se_o,
  output logic [CTRL_WIDTH-1:0] ctrl_q2_o,
  output logic                  stall_o,
  output logic                  illegal_o
);

  logic [REG_AW-1:0] rs1, rs2;
  ctrl_t             ctrl;
  logic              legal, uses_rs1, uses_rs2, hazard;

  assign rs1       = instr_i[19:15];
  assign rs2       = instr_i[24:20];
  assign pc_incr_o = pc_incr_i;
  assign wr_addr_o = {{(XLEN-REG_AW){1'b0}}, instr_i[11:7]};

  id_stage_regfile u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs1_addr_i (rs1),
    .rs2_addr_i (rs2),
    .rd_data1_o (rd_data1_o),
    .rd_data2_o (rd_data2_o),
    .wr_en_i    (wb_en_i),
    .wr_addr_i  (wb_addr_i),
    .wr_data_i  (wb_data_i)
  );

  // Decode: control word, immediate and which source registers are read.
  // Matching the full 7-bit opcode also rejects instr_i[1:0] != 2'b11.
  always_comb begin
    ctrl     = '0;
    imm_se_o = '0;
    legal    = 1'b1;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode_e'(instr_i[6:0]))
      OPC_LUI, OPC_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm_se_o       = {instr_i[31:12], 12'b0};
      end
      OPC_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.jal       = 1'b1;
        imm_se_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                    instr_i[30:21], 1'b0};
      end
      OPC_JALR: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.jalr      = 1'b1;
        uses_rs1       = 1'b1;
        imm_se_o       = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OPC_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_OP_BRANCH;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
        imm_se_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                    instr_i[11:8], 1'b0};
      end
      OPC_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        uses_rs1        = 1'b1;
        imm_se_o        = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OPC_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
        imm_se_o       = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      OPC_OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_OP_FUNCT;
        uses_rs1       = 1'b1;
        imm_se_o       = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OPC_OP: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OP_FUNCT;
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // Load-use: the load in IDEX has not produced its data yet, so hold this
  // instruction one cycle. Fields of rs1/rs2 that the format does not read are
  // ignored, otherwise immediate bits would cause false stalls.
  assign hazard = idex_mem_read_i && (idex_rd_i != '0) &&
                  ((uses_rs1 && idex_rd_i == rs1) || (uses_rs2 && idex_rd_i == rs2));

  assign illegal_o = !legal;
  assign stall_o   = hazard && !flush_i;
  assign ctrl_q2_o = (flush_i || hazard || !legal) ? '0 : ctrl;

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_i, pc_incr_i;
  logic        flush_i, idex_mem_read_i;
  logic [4:0]  idex_rd_i;
  logic        wb_en_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic [31:0] pc_incr_o, rd_data1_o, rd_data2_o, wr_addr_o, imm_se_o;
  logic [9:0]  ctrl_q2_o;
  logic        stall_o, illegal_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .instr_i         (instr_i),
    .pc_incr_i       (pc_incr_i),
    .flush_i         (flush_i),
    .idex_mem_read_i (idex_mem_read_i),
    .idex_rd_i       (idex_rd_i),
    .wb_en_i         (wb_en_i),
    .wb_addr_i       (wb_addr_i),
    .wb_data_i       (wb_data_i),
    .pc_incr_o       (pc_incr_o),
    .rd_data1_o      (rd_data1_o),
    .rd_data2_o      (rd_data2_o),
    .wr_addr_o       (wr_addr_o),
    .imm_se_o        (imm_se_o),
    .ctrl_q2_o       (ctrl_q2_o),
    .stall_o         (stall_o),
    .illegal_o       (illegal_o)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, actual, expected);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        mem_rd;
    logic [4:0]  idex_rd;
    logic        flush;
    logic [9:0]  exp_ctrl;
    logic [31:0] exp_imm;
    logic [4:0]  exp_rd;
    logic        exp_stall;
    logic        exp_illegal;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst_n = 1'b0; instr_i = '0; pc_incr_i = 32'h0000_1004; flush_i = 1'b0;
    idex_mem_read_i = 1'b0; idex_rd_i = '0;
    wb_en_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;

    // Reset state with the IF/ID reset instruction.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("rst_ctrl", 32'(ctrl_q2_o), 32'h0);
    check("rst_illegal", 32'(illegal_o), 32'h1);
    check("rst_stall", 32'(stall_o), 32'h0);
    check("pc_pass", pc_incr_o, 32'h0000_1004);
    for (int r = 1; r < 32; r++) begin
      instr_i = {7'b0, r[4:0], r[4:0], 3'b0, 5'd1, 7'b0110011};
      #1;
      check($sformatf("rst_rd1_x%0d", r), rd_data1_o, 32'h0);
      check($sformatf("rst_rd2_x%0d", r), rd_data2_o, 32'h0);
    end

    // Decode table.
    vecs.push_back('{"addi_m1",  32'hFFF00093, 0, 0, 0, 10'h211, 32'hFFFFFFFF, 5'd1, 0, 0});
    vecs.push_back('{"beq_m4",   32'hFE000EE3, 0, 0, 0, 10'h120, 32'hFFFFFFFC, 5'd29, 0, 0});
    vecs.push_back('{"lui",      32'h123452B7, 0, 0, 0, 10'h011, 32'h12345000, 5'd5, 0, 0});
    vecs.push_back('{"auipc",    32'hFFFFF217, 0, 0, 0, 10'h011, 32'hFFFFF000, 5'd4, 0, 0});
    vecs.push_back('{"jal_800",  32'h001000EF, 0, 0, 0, 10'h041, 32'h00000800, 5'd1, 0, 0});
    vecs.push_back('{"jalr",     32'h00008067, 0, 0, 0, 10'h091, 32'h00000000, 5'd0, 0, 0});
    vecs.push_back('{"lw_m8",    32'hFF812183, 0, 0, 0, 10'h01B, 32'hFFFFFFF8, 5'd3, 0, 0});
    vecs.push_back('{"sw_8",     32'h0062A423, 0, 0, 0, 10'h014, 32'h00000008, 5'd8, 0, 0});
    vecs.push_back('{"add_r",    32'h006283B3, 0, 0, 0, 10'h201, 32'h00000000, 5'd7, 0, 0});
    vecs.push_back('{"fence",    32'h0000000F, 0, 0, 0, 10'h000, 32'h00000000, 5'd0, 0, 1});
    vecs.push_back('{"low_bits", 32'h006283B1, 0, 0, 0, 10'h000, 32'h00000000, 5'd7, 0, 1});
    vecs.push_back('{"lu_rs1",   32'h006283B3, 1, 5, 0, 10'h000, 32'h00000000, 5'd7, 1, 0});
    vecs.push_back('{"lu_rs2",   32'h006283B3, 1, 6, 0, 10'h000, 32'h00000000, 5'd7, 1, 0});
    vecs.push_back('{"lu_lui",   32'h123452B7, 1, 5, 0, 10'h011, 32'h12345000, 5'd5, 0, 0});
    vecs.push_back('{"lu_x0",    32'h006283B3, 1, 0, 0, 10'h201, 32'h00000000, 5'd7, 0, 0});
    vecs.push_back('{"no_load",  32'h006283B3, 0, 5, 0, 10'h201, 32'h00000000, 5'd7, 0, 0});
    vecs.push_back('{"imm_rs2",  32'h00628093, 1, 6, 0, 10'h211, 32'h00000006, 5'd1, 0, 0});
    vecs.push_back('{"sw_rs2",   32'h0062A423, 1, 6, 0, 10'h000, 32'h00000008, 5'd8, 1, 0});
    vecs.push_back('{"lu_flush", 32'h006283B3, 1, 5, 1, 10'h000, 32'h00000000, 5'd7, 0, 0});
    vecs.push_back('{"flush",    32'hFFF00093, 0, 0, 1, 10'h000, 32'hFFFFFFFF, 5'd1, 0, 0});

    foreach (vecs[i]) begin
      instr_i = vecs[i].instr; idex_mem_read_i = vecs[i].mem_rd;
      idex_rd_i = vecs[i].idex_rd; flush_i = vecs[i].flush;
      #1;
      check({vecs[i].name, "_ctrl"}, 32'(ctrl_q2_o), 32'(vecs[i].exp_ctrl));
      check({vecs[i].name, "_imm"}, imm_se_o, vecs[i].exp_imm);
      check({vecs[i].name, "_wr"}, wr_addr_o, 32'(vecs[i].exp_rd));
      check({vecs[i].name, "_stall"}, 32'(stall_o), 32'(vecs[i].exp_stall));
      check({vecs[i].name, "_illegal"}, 32'(illegal_o), 32'(vecs[i].exp_illegal));
    end
    idex_mem_read_i = 1'b0; idex_rd_i = '0; flush_i = 1'b0;

    // Write x5 with same-cycle bypass, then read it from the array.
    @(negedge clk);
    instr_i = 32'h00028333;  // add x6,x5,x0
    wb_en_i = 1'b1; wb_addr_i = 5'd5; wb_data_i = 32'hDEADBEEF;
    #1;
    check("byp_rd1", rd_data1_o, 32'hDEADBEEF);
    check("byp_rd2_x0", rd_data2_o, 32'h0);
    @(negedge clk);
    wb_en_i = 1'b0; wb_data_i = 32'h0;
    #1;
    check("arr_rd1", rd_data1_o, 32'hDEADBEEF);

    // Second register on port 2; bypass and array together.
    instr_i = 32'h006283B3;  // add x7,x5,x6
    wb_en_i = 1'b1; wb_addr_i = 5'd6; wb_data_i = 32'h0BADF00D;
    #1;
    check("byp_rd2", rd_data2_o, 32'h0BADF00D);
    check("arr_rd1_b", rd_data1_o, 32'hDEADBEEF);
    @(negedge clk);
    wb_en_i = 1'b0;
    #1;
    check("arr_rd2", rd_data2_o, 32'h0BADF00D);

    // Write to x0 is ignored, now and later.
    instr_i = 32'h00000333;  // add x6,x0,x0
    wb_en_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 32'h00001234;
    #1;
    check("x0_same_rd1", rd_data1_o, 32'h0);
    check("x0_same_rd2", rd_data2_o, 32'h0);
    @(negedge clk);
    wb_en_i = 1'b0;
    #1;
    check("x0_next_rd1", rd_data1_o, 32'h0);

    // Reset asserted while a write is pending discards it and clears x5/x6.
    instr_i = 32'h007283B3;  // add x7,x5,x7
    wb_en_i = 1'b1; wb_addr_i = 5'd7; wb_data_i = 32'h00000055;
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; wb_en_i = 1'b0;
    #1;
    check("rstw_rd1_x5", rd_data1_o, 32'h0);
    check("rstw_rd2_x7", rd_data2_o, 32'h0);
    instr_i = 32'h00000333 | (32'd6 << 15);  // add x6,x6,x0
    #1;
    check("rstw_rd1_x6", rd_data1_o, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
